// File: rtl/shift_sequencer_8bit.sv
// ---------------------------------------------------------------------------
// shift_sequencer_8bit
//
// Purpose:
//   Multi-step right-shift engine built around the combinational one-position
//   shift-right unit SRU_8bit. On an accepted start it latches an operand,
//   carry-in, mode and step count. It then applies one single-bit shift per
//   clock by feeding the registered result and carry back into SRU_8bit. When
//   the programmed number of steps is finished, it pulses done for one cycle.
//
// Ports (shift_sequencer_8bit):
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      operation request, only honoured in IDLE
//   x      in   8      operand, latched on an accepted start
//   sel0   in   1      mode select LSB, latched on an accepted start
//   sel1   in   1      mode select MSB, latched on an accepted start
//   cin    in   1      initial carry, latched on an accepted start
//   count  in   CNT_W  number of one-bit shift steps (0 .. 2^CNT_W-1)
//   f      out  8      result register (intermediate value while busy)
//   cout   out  1      carry register, last bit shifted out
//   busy   out  1      high while shifting
//   done   out  1      one-cycle completion pulse
//
// Mode encoding {sel1,sel0}:
//   00 LSR  logical shift right, zero fill
//   01 RR   rotate right
//   10 RRC  rotate right through carry
//   11 ASR  arithmetic shift right, sign fill
// In every mode the carry out is the bit leaving position 0.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// SRU_8bit
//
// Purpose:
//   Purely combinational one-position shift-right unit. It is the single step
//   function that the sequencer iterates.
//
// Ports (SRU_8bit):
//   x     in   8   operand
//   cin   in   1   carry in, used as the fill bit in RRC mode
//   sel0  in   1   mode select LSB
//   sel1  in   1   mode select MSB
//   f     out  8   operand shifted right by one position
//   cout  out  1   bit shifted out of position 0
// ---------------------------------------------------------------------------
module SRU_8bit (
  input  logic [7:0] x,
  input  logic       cin,
  input  logic       sel0,
  input  logic       sel1,
  output logic [7:0] f,
  output logic       cout
);

  // The low seven result bits always come from x[7:1]. Only the fill bit
  // entering position 7 depends on the mode. The bit leaving position 0 is
  // the carry out in all four modes.
  always_comb begin
    f    = {1'b0, x[7:1]};
    cout = x[0];
    case ({sel1, sel0})
      2'b00:   f = {1'b0, x[7:1]};
      2'b01:   f = {x[0], x[7:1]};
      2'b10:   f = {cin,  x[7:1]};
      default: f = {x[7], x[7:1]};
    endcase
  end

endmodule

module shift_sequencer_8bit #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       x,
  input  logic             sel0,
  input  logic             sel1,
  input  logic             cin,
  input  logic [CNT_W-1:0] count,
  output logic [7:0]       f,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  // IDLE  : waiting for start, result registers hold the last answer
  // SHIFT : one SRU step per clock until the step counter runs out
  // DONE  : single-cycle completion marker, result registers hold
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       f_q, f_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       mode_q, mode_d;

  logic [7:0]       stepF;
  logic             stepCout;

  // The step unit always looks at the registered value, carry and latched
  // mode. Its output is committed only in SHIFT, so it is free to compute
  // something meaningless in the other states.
  SRU_8bit u_sru (
    .x    (f_q),
    .cin  (cout_q),
    .sel0 (mode_q[0]),
    .sel1 (mode_q[1]),
    .f    (stepF),
    .cout (stepCout)
  );

  // State and datapath registers. Reset drops everything to a clean IDLE
  // with a zero result. If reset arrives mid-operation, the DONE state is
  // never reached, so no completion pulse is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      f_q         <= 8'h00;
      cout_q      <= 1'b0;
      remaining_q <= '0;
      mode_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      f_q         <= f_d;
      cout_q      <= cout_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
    end
  end

  // Next-state and datapath update. Every register defaults to holding,
  // so inputs only matter on the accepted-start edge in IDLE. Changes to
  // x/sel/cin/count afterwards, or a start pulse while busy or in DONE, have
  // no effect.
  always_comb begin
    state_d     = state_q;
    f_d         = f_q;
    cout_d      = cout_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          f_d         = x;
          cout_d      = cin;
          remaining_d = count;
          mode_d      = {sel1, sel0};
          // A zero count skips SHIFT. The loaded operand is the answer, and
          // done follows straight after the start edge.
          state_d     = (count != '0) ? SHIFT : DONE;
        end
      end

      SHIFT: begin
        f_d    = stepF;
        cout_d = stepCout;
        // The guard keeps the counter from wrapping. SHIFT is never entered
        // with zero remaining, but the counter must not run below zero anyway.
        if (remaining_q != '0) begin
          remaining_d = remaining_q - CNT_W'(1);
        end
        // With one step left, this edge performs the final step.
        if (remaining_q <= CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the state register alone. They are
  // glitch-free with respect to the inputs, and busy and done are mutually
  // exclusive by construction.
  assign f    = f_q;
  assign cout = cout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_sequencer_8bit.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer_8bit
//
// Scoreboard bench for shift_sequencer_8bit. The stimulus side issues
// operations and pushes the expected result, carry, completion cycle and busy
// length into a queue. A separate monitor pops an entry whenever done is
// seen and compares against it. Expected values come from a reference model
// that uses whole-word shifts and rotates rather than single-bit stepping.
// ---------------------------------------------------------------------------
module tb_shift_sequencer_8bit;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       x;
  logic             sel0;
  logic             sel1;
  logic             cin;
  logic [CNT_W-1:0] count;
  logic [7:0]       f;
  logic             cout;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busyCnt = 0;

  typedef struct {
    logic [7:0] f;
    logic       c;
    int         doneCyc;
    int         busyLen;
  } exp_t;

  exp_t sbq[$];
  exp_t lastExp;
  exp_t monExp;

  shift_sequencer_8bit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .sel0  (sel0),
    .sel1  (sel1),
    .cin   (cin),
    .count (count),
    .f     (f),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to time-stamp start and done.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: n-position result computed directly from the operand
  // with whole-word shift and rotate arithmetic. Returns {cout, f}.
  function automatic logic [8:0] refModel(input logic [7:0] xv, input logic [1:0] m,
                                          input logic ci, input int n);
    logic [15:0] dbl;
    logic [17:0] nine2;
    logic [17:0] rot9;
    logic [7:0]  r;
    logic        c;
    if (n == 0) return {ci, xv};
    c = xv[n-1];
    case (m)
      2'd0: r = xv >> n;
      2'd1: begin
        dbl = {xv, xv};
        r   = 8'(dbl >> n);
      end
      2'd2: begin
        // Rotate right through a 9-bit ring {carry, operand}.
        nine2 = {ci, xv, ci, xv};
        rot9  = nine2 >> n;
        r     = rot9[7:0];
        c     = rot9[8];
      end
      default: r = 8'($signed(xv) >>> n);
    endcase
    return {c, r};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Issue one operation, then scramble the inputs to show they are not
  // re-sampled after the start edge.
  task automatic applyStimulus(input logic [7:0] xv, input logic [1:0] m,
                               input logic ci, input int n);
    exp_t e;
    logic [8:0] r;
    @(negedge clk);
    x     = xv;
    sel1  = m[1];
    sel0  = m[0];
    cin   = ci;
    count = n[CNT_W-1:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = 8'($urandom);
    {sel1, sel0} = 2'($urandom);
    cin   = 1'($urandom);
    count = CNT_W'($urandom);
    r = refModel(xv, m, ci, n);
    e.f       = r[7:0];
    e.c       = r[8];
    e.doneCyc = cyc + n;
    e.busyLen = n;
    lastExp   = e;
    sbq.push_back(e);
  endtask

  // Bounded wait for the monitor to consume the outstanding expectation,
  // then confirm the result holds once back in IDLE.
  task automatic waitDone(input string name);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (sbq.size() == 0) break;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout actual=pending required=done", name);
      sbq.delete();
    end
    @(negedge clk);
    checkOutput({name, "_hold_f"}, 32'(f), 32'(lastExp.f));
    checkOutput({name, "_hold_cout"}, 32'(cout), 32'(lastExp.c));
  endtask

  // Monitor: counts busy cycles and scores every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      busyCnt = 0;
    end else begin
      if (busy) busyCnt++;
      if (done) begin
        checkOutput("busy_with_done", 32'(busy), 32'd0);
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done actual=1 required=0");
        end else begin
          monExp = sbq.pop_front();
          checkOutput("result_f", 32'(f), 32'(monExp.f));
          checkOutput("result_cout", 32'(cout), 32'(monExp.c));
          checkOutput("done_cycle", 32'(cyc), 32'(monExp.doneCyc));
          checkOutput("busy_len", 32'(busyCnt), 32'(monExp.busyLen));
        end
        busyCnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    x     = 8'h00;
    sel0  = 1'b0;
    sel1  = 1'b0;
    cin   = 1'b0;
    count = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_f", 32'(f), 32'h00);
    checkOutput("reset_cout", 32'(cout), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    // LSR, RR, RRC (with in-flight checks) and ASR with an ignored start.
    applyStimulus(8'b10100111, 2'b00, 1'b1, 3);
    waitDone("lsr3");
    applyStimulus(8'b10100111, 2'b01, 1'b1, 3);
    waitDone("rr3");

    applyStimulus(8'b10100111, 2'b10, 1'b0, 2);
    @(posedge clk); #1;
    checkOutput("rrc_step1_f", 32'(f), 32'b01010011);
    checkOutput("rrc_step1_cout", 32'(cout), 32'd1);
    @(posedge clk); #1;
    checkOutput("rrc_step2_f", 32'(f), 32'b10101001);
    checkOutput("rrc_step2_cout", 32'(cout), 32'd1);
    waitDone("rrc2");

    applyStimulus(8'b10100111, 2'b11, 1'b0, 7);
    @(negedge clk);
    x = 8'h00; {sel1, sel0} = 2'b00; cin = 1'b1; count = CNT_W'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("asr7");
    checkOutput("asr7_final_f", 32'(f), 32'hFF);
    checkOutput("asr7_final_cout", 32'(cout), 32'd0);

    // Zero count: done right after the start edge, no busy.
    applyStimulus(8'h5A, 2'b00, 1'b1, 0);
    waitDone("zero");

    // Asynchronous reset in the middle of an LSR by 7.
    applyStimulus(8'b10100111, 2'b00, 1'b1, 7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("pre_reset_f", 32'(f), 32'b00101001);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_f", 32'(f), 32'h00);
    checkOutput("async_reset_cout", 32'(cout), 32'd0);
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_done", 32'(done), 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    checkOutput("reset_hold_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_no_done", 32'(done), 32'd0);
    applyStimulus(8'hC3, 2'b00, 1'b0, 4);
    waitDone("after_reset");

    // Randomised operations across all modes and counts.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7));
      waitDone("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer_8bit.md
Name: shift_sequencer_8bit

Overview:
- Multi-step shift engine placed directly downstream of SRU_8bit.
- Registers the SRU_8bit result and carry-out, then feeds them back as the next operand and carry-in.
- Applies one single-bit right shift per clock, repeated a programmable number of times.
- Turns the combinational one-position shift-right unit into an N-position shifter with start/busy/done handshake, for the datapath's multi-bit shift instructions.

Parameters:
- CNT_W, 3, width of the shift-count input; max count 2^CNT_W-1 = 7.

Ports:
- clk    input   1      system clock, rising edge
- rst    input   1      reset, asynchronous, active-high
- start  input   1      request; sampled only in IDLE
- x      input   8      operand, latched on accepted start
- sel0   input   1      mode select LSB, latched on accepted start
- sel1   input   1      mode select MSB, latched on accepted start
- cin    input   1      initial carry, latched on accepted start
- count  input   CNT_W  number of one-bit shift steps, latched on accepted start
- f      output  8      result register (intermediate value while busy)
- cout   output  1      carry register: last bit shifted out
- busy   output  1      high while in SHIFT
- done   output  1      one-cycle completion pulse

Behaviour:
- Reset (async, active-high):
  - state=IDLE, f=8'h00, cout=0, busy=0, done=0, remaining=0, latched mode=00.
  - Reset asserted mid-operation aborts immediately to these values; no done pulse.
- Mode encoding {sel1,sel0}, same as SRU_8bit:
  - 00 LSR: f <= {0, f[7:1]}
  - 01 RR: f <= {f[0], f[7:1]}
  - 10 RRC: f <= {cout, f[7:1]}
  - 11 ASR: f <= {f[7], f[7:1]}
- Carry rule: every step in every mode sets cout <= f[0] (pre-step value).
- Step function: computed by an instance of SRU_8bit, fed x=f, cin=cout, sel=latched mode.
- States:
  - IDLE:
    - start=1 → load f<=x, cout<=cin, remaining<=count, latch mode.
    - Next state: SHIFT if count!=0, else DONE.
    - start=0 → hold all registers.
  - SHIFT:
    - busy=1.
    - Each edge: apply one step, remaining <= remaining-1.
    - When remaining==1 at the edge: perform the final step and go to DONE.
  - DONE:
    - done=1, busy=0 for exactly one cycle; f and cout hold.
    - Next edge → IDLE.
- Latency: start sampled at edge 0. N shift steps occur at edges 1..N. done is high during the cycle after edge N+? where:
  - count=0: done is high in the cycle after edge 0.
  - count=N>0: done is high in the cycle after edge N.
- f and cout hold the final result in IDLE until the next accepted start.
- start while busy or in DONE is ignored. It is not queued and inputs are not re-latched.
- x, sel0, sel1, cin, count may change freely after the start edge without affecting the operation.
- busy and done are never high simultaneously.
- No wrap or overflow on remaining: it only decrements while nonzero.

Test Plan:
- LSR, x=8'b10100111, cin=1, sel=00, count=3 → after edge 3: f=8'b00010100, cout=1, done pulse 1 cycle, busy high for 3 cycles.
- RR, same x, sel1=0 sel0=1, count=3 → f=8'b11110100, cout=1.
- RRC, same x, cin=0, sel1=1 sel0=0, count=2:
  - after edge 1: f=8'b01010011, cout=1
  - after edge 2: f=8'b10101001, cout=1
- ASR, same x, sel=11, count=7 → f=8'b11111111, cout=0. Pulse start again while busy; it is ignored and the result is unchanged.
- count=0, x=8'h5A, cin=1 → f=8'h5A, cout=1, done high in the cycle after the start edge, busy never high.
- Assert rst asynchronously mid-SHIFT (LSR, count=7, after 2 steps) → f=0, cout=0, busy=0 immediately, no done. After release, a new start completes normally.
